// File: rtl/score_seg_scan_pkg.sv
// Shared constants and types for the score seven-segment scanner.
// Segment patterns are active low, ordered {g,f,e,d,c,b,a}.
package score_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [3:0] AN_OFF    = 4'hF;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  typedef enum logic [1:0] {
    SLOT_ONES     = 2'd0,
    SLOT_TENS     = 2'd1,
    SLOT_HUNDREDS = 2'd2,
    SLOT_UNUSED   = 2'd3
  } digit_idx_t;

endpackage

// File: rtl/score_seg_scan_if.sv
// Score digits in, display drive out. The blink request exists only
// when SCORE_BLINK_EN is defined.
interface score_seg_scan_if;

  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
`ifdef SCORE_BLINK_EN
  logic       blink;
`endif
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

`ifdef SCORE_BLINK_EN
  modport master (output hundreds, tens, ones, blink, input an, seg, dp);
  modport slave  (input hundreds, tens, ones, blink, output an, seg, dp);
`else
  modport master (output hundreds, tens, ones, input an, seg, dp);
  modport slave  (input hundreds, tens, ones, output an, seg, dp);
`endif

endinterface

// File: rtl/score_seg_scan_seg7_decode.sv
// BCD digit to active-low seven-segment pattern; non-BCD codes show a dash.
module seg7_decode
  import score_seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (bcd <= 4'd9) seg = SEG_DIGIT[bcd];
  end

endmodule

// File: rtl/score_seg_scan.sv
// Time-multiplexes a 3-digit BCD score onto a 4-digit common-anode display.
// Build option SCORE_BLINK_EN adds the blink input and frame-rate flashing.
module score_seg_scan
  import score_seg_pkg::*;
#(
  parameter int REFRESH_TICKS = 100000,
  parameter int BLANK_TICKS   = 1000,
  parameter int BLINK_FRAMES  = 250
) (
  input logic             clk,
  input logic             rst_n,
  score_seg_scan_if.slave bus
);

  localparam int CNT_W = $clog2(REFRESH_TICKS);

  if (REFRESH_TICKS < 4 || BLANK_TICKS < 1 || BLANK_TICKS > REFRESH_TICKS - 2 ||
      BLINK_FRAMES < 1) begin : g_bad_params
    $error("score_seg_scan: illegal REFRESH_TICKS/BLANK_TICKS/BLINK_FRAMES");
  end

  logic [CNT_W-1:0] cnt;
  digit_idx_t       idx;
  logic [3:0]       sh_hundreds;
  logic [3:0]       sh_tens;
  logic [3:0]       sh_ones;
  logic             frame_start;
  logic             slot_end;

  assign frame_start = (cnt == '0) && (idx == SLOT_ONES);
  assign slot_end    = (cnt == CNT_W'(REFRESH_TICKS - 1));

  // Slot counter and once-per-frame digit capture keep a frame tear-free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      idx         <= SLOT_ONES;
      sh_hundreds <= '0;
      sh_tens     <= '0;
      sh_ones     <= '0;
    end else begin
      if (slot_end) begin
        cnt <= '0;
        idx <= digit_idx_t'(idx + 2'd1);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (frame_start) begin
        sh_hundreds <= bus.hundreds;
        sh_tens     <= bus.tens;
        sh_ones     <= bus.ones;
      end
    end
  end

  logic suppress;

`ifdef SCORE_BLINK_EN
  localparam int FRAME_W = $clog2(BLINK_FRAMES + 1);

  logic [FRAME_W-1:0] frame_cnt;
  logic               blink_phase;

  // Dropping blink clears the phase so the display comes back at once.
  always_ff @(posedge clk) begin
    if (!rst_n || !bus.blink) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_start) begin
      if (frame_cnt == FRAME_W'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + FRAME_W'(1);
      end
    end
  end

  assign suppress = bus.blink & blink_phase;
`else
  assign suppress = 1'b0;
`endif

  // Stage p0: pick the slot digit, apply guard and leading-zero blanking.
  logic [3:0] digit_p0;
  logic [6:0] dec_p0;
  logic       dark_p0;
  logic [3:0] an_p0;
  logic [6:0] seg_p0;

  always_comb begin
    digit_p0 = sh_ones;
    dark_p0  = 1'b0;
    unique case (idx)
      SLOT_ONES:     digit_p0 = sh_ones;
      SLOT_TENS: begin
        digit_p0 = sh_tens;
        dark_p0  = (sh_hundreds == 4'd0) && (sh_tens == 4'd0);
      end
      SLOT_HUNDREDS: begin
        digit_p0 = sh_hundreds;
        dark_p0  = (sh_hundreds == 4'd0);
      end
      SLOT_UNUSED:   dark_p0 = 1'b1;
      default:       dark_p0 = 1'b1;
    endcase
    if (cnt < CNT_W'(BLANK_TICKS) || suppress) dark_p0 = 1'b1;
  end

  seg7_decode u_decode (
    .bcd (digit_p0),
    .seg (dec_p0)
  );

  always_comb begin
    an_p0  = AN_OFF;
    seg_p0 = SEG_BLANK;
    if (!dark_p0) begin
      an_p0  = ~(4'b0001 << idx);
      seg_p0 = dec_p0;
    end
  end

  // Stage p1: registered display drive, no input-to-output path.
  logic [3:0] an_p1;
  logic [6:0] seg_p1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an_p1  <= AN_OFF;
      seg_p1 <= SEG_BLANK;
    end else begin
      an_p1  <= an_p0;
      seg_p1 <= seg_p0;
    end
  end

  assign bus.an  = an_p1;
  assign bus.seg = seg_p1;
  assign bus.dp  = 1'b1;

endmodule

// File: tb/tb_score_seg_scan.sv
// Bench for score_seg_scan with short slots; a cycle model feeds a scoreboard.
// Blink scenarios are included when SCORE_BLINK_EN is defined.
module tb_score_seg_scan;

  localparam int RT = 8;
  localparam int BT = 2;
  localparam int BF = 2;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic [2:0] cnt;
    logic [1:0] idx;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  exp_t e;

  logic [2:0] m_cnt;
  logic [1:0] m_idx;
  logic [3:0] m_h, m_t, m_o;
`ifdef SCORE_BLINK_EN
  int   m_fc;
  logic m_ph;
`endif

  always #5 clk = ~clk;

  score_seg_scan_if bus ();

  score_seg_scan #(.REFRESH_TICKS(RT), .BLANK_TICKS(BT), .BLINK_FRAMES(BF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    case (d)
      4'd0: ref_seg = 7'b1000000;  4'd1: ref_seg = 7'b1111001;
      4'd2: ref_seg = 7'b0100100;  4'd3: ref_seg = 7'b0110000;
      4'd4: ref_seg = 7'b0011001;  4'd5: ref_seg = 7'b0010010;
      4'd6: ref_seg = 7'b0000010;  4'd7: ref_seg = 7'b1111000;
      4'd8: ref_seg = 7'b0000000;  4'd9: ref_seg = 7'b0010000;
      default: ref_seg = 7'b0111111;
    endcase
  endfunction

  // Reference model: what the display must show after each rising edge.
  always @(posedge clk) begin : model
    exp_t ex;
    logic dark;
    logic [3:0] dg;
    if (!rst_n) begin
      ex = '{an: 4'hF, seg: 7'h7F, cnt: 3'd0, idx: 2'd0};
      m_cnt <= 3'd0; m_idx <= 2'd0; m_h <= 4'd0; m_t <= 4'd0; m_o <= 4'd0;
`ifdef SCORE_BLINK_EN
      m_fc <= 0; m_ph <= 1'b0;
`endif
    end else begin
      dg   = (m_idx == 2'd0) ? m_o : (m_idx == 2'd1) ? m_t : m_h;
      dark = (int'(m_cnt) < BT) || (m_idx == 2'd3) || (m_idx == 2'd2 && m_h == 4'd0) ||
             (m_idx == 2'd1 && m_h == 4'd0 && m_t == 4'd0);
`ifdef SCORE_BLINK_EN
      if (bus.blink && m_ph) dark = 1'b1;
      if (!bus.blink) begin
        m_fc <= 0; m_ph <= 1'b0;
      end else if (m_cnt == 3'd0 && m_idx == 2'd0) begin
        if (m_fc == BF - 1) begin m_fc <= 0; m_ph <= !m_ph; end
        else m_fc <= m_fc + 1;
      end
`endif
      ex.an  = dark ? 4'hF : ~(4'b0001 << m_idx);
      ex.seg = dark ? 7'h7F : ref_seg(dg);
      ex.cnt = m_cnt;
      ex.idx = m_idx;
      if (m_cnt == 3'd0 && m_idx == 2'd0) begin
        m_h <= bus.hundreds; m_t <= bus.tens; m_o <= bus.ones;
      end
      if (m_cnt == 3'(RT - 1)) begin m_cnt <= 3'd0; m_idx <= m_idx + 2'd1; end
      else m_cnt <= m_cnt + 3'd1;
    end
    sb.push_back(ex);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    e = sb.pop_front();
  endtask

  task automatic set_score(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    bus.hundreds = h; bus.tens = t; bus.ones = o;
  endtask

  task automatic sync_frame();
    int g = 0;
    while (!(m_cnt == 3'd0 && m_idx == 2'd0) && g < 40) begin tick(); g++; end
    if (g >= 40) begin
      n_cmp++; n_bad++;
      $display("FAIL sync_frame: no frame start within %0d cycles (idx=%0d cnt=%0d)", g, m_idx, m_cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_score(4'd1, 4'd0, 4'd7);
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if ({bus.an, bus.seg, bus.dp} !== {4'hF, 7'h7F, 1'b1}) begin
        n_bad++;
        $display("FAIL reset_hold: an=%b seg=%b dp=%b, required an=1111 seg=1111111 dp=1", bus.an, bus.seg, bus.dp);
      end
    end
  endtask

  task automatic test_first_frame();
    logic [3:0] ca;
    logic [6:0] cs;
    rst_n = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      tick();
      n_cmp++;
      if ({bus.an, bus.seg, bus.dp} !== {e.an, e.seg, 1'b1}) begin
        n_bad++;
        $display("FAIL first_frame_sb k=%0d: an=%b seg=%b dp=%b, required an=%b seg=%b dp=1", k, bus.an, bus.seg, bus.dp, e.an, e.seg);
      end
      ca = 4'hF; cs = 7'h7F;
      if (k >= 3 && k <= 8)        begin ca = 4'b1110; cs = 7'b1111000; end
      else if (k >= 11 && k <= 16) begin ca = 4'b1101; cs = 7'b1000000; end
      else if (k >= 19 && k <= 24) begin ca = 4'b1011; cs = 7'b1111001; end
      n_cmp++;
      if ({bus.an, bus.seg} !== {ca, cs}) begin
        n_bad++;
        $display("FAIL first_frame_const k=%0d: an=%b seg=%b, required an=%b seg=%b", k, bus.an, bus.seg, ca, cs);
      end
    end
  endtask

  task automatic test_blanking();
    int lit;
    logic [6:0] want;
    for (int c = 0; c < 2; c++) begin
      sync_frame();
      set_score(4'd0, 4'd0, (c == 0) ? 4'd5 : 4'd0);
      want = (c == 0) ? 7'b0010010 : 7'b1000000;
      lit = 0;
      for (int k = 1; k <= 64; k++) begin
        tick();
        n_cmp++;
        if ({bus.an, bus.seg, bus.dp} !== {e.an, e.seg, 1'b1}) begin
          n_bad++;
          $display("FAIL blank_sb c=%0d k=%0d: an=%b seg=%b, required an=%b seg=%b", c, k, bus.an, bus.seg, e.an, e.seg);
        end
        n_cmp++;
        if (bus.an[3:1] !== 3'b111) begin
          n_bad++;
          $display("FAIL blank_upper c=%0d k=%0d: an=%b, required an[3:1]=111", c, k, bus.an);
        end
        if (bus.an[0] === 1'b0) begin
          lit++;
          n_cmp++;
          if (bus.seg !== want) begin
            n_bad++;
            $display("FAIL blank_ones c=%0d k=%0d: seg=%b, required %b", c, k, bus.seg, want);
          end
        end
      end
      n_cmp++;
      if (lit !== 12) begin
        n_bad++;
        $display("FAIL blank_lit_count c=%0d: got %0d, required 12", c, lit);
      end
    end
  endtask

  task automatic test_mid_frame();
    int lit2 = 0;
    sync_frame();
    set_score(4'd0, 4'd2, 4'd8);
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (k == 12) bus.hundreds = 4'd1;
      n_cmp++;
      if ({bus.an, bus.seg, bus.dp} !== {e.an, e.seg, 1'b1}) begin
        n_bad++;
        $display("FAIL mid_sb k=%0d: an=%b seg=%b, required an=%b seg=%b", k, bus.an, bus.seg, e.an, e.seg);
      end
      if (k <= 32) begin
        n_cmp++;
        if (bus.an[2] !== 1'b1) begin
          n_bad++;
          $display("FAIL mid_no_tear k=%0d: an=%b, required an[2]=1", k, bus.an);
        end
      end else if (bus.an[2] === 1'b0) begin
        lit2++;
        n_cmp++;
        if (bus.seg !== 7'b1111001) begin
          n_bad++;
          $display("FAIL mid_hundreds k=%0d: seg=%b, required 1111001", k, bus.seg);
        end
      end
    end
    n_cmp++;
    if (lit2 !== 6) begin
      n_bad++;
      $display("FAIL mid_next_frame: an[2] lit %0d cycles, required 6", lit2);
    end
  endtask

  task automatic test_guard();
    sync_frame();
    set_score(4'd1, 4'd2, 4'd3);
    for (int k = 1; k <= 96; k++) begin
      tick();
      n_cmp++;
      if ({bus.an, bus.seg, bus.dp} !== {e.an, e.seg, 1'b1}) begin
        n_bad++;
        $display("FAIL guard_sb k=%0d: an=%b seg=%b, required an=%b seg=%b", k, bus.an, bus.seg, e.an, e.seg);
      end
      n_cmp++;
      if ($countones(~bus.an) > 1) begin
        n_bad++;
        $display("FAIL guard_one_hot k=%0d: an=%b, required at most one low", k, bus.an);
      end
      if (int'(e.cnt) < BT) begin
        n_cmp++;
        if (bus.an !== 4'hF) begin
          n_bad++;
          $display("FAIL guard_off k=%0d: an=%b, required 1111", k, bus.an);
        end
      end
    end
  endtask

  task automatic test_dash_reset();
    int g = 0;
    sync_frame();
    set_score(4'd0, 4'd0, 4'hC);
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_cmp++;
      if ({bus.an, bus.seg} !== ((k >= 3) ? {4'b1110, 7'b0111111} : {4'hF, 7'h7F})) begin
        n_bad++;
        $display("FAIL dash k=%0d: an=%b seg=%b, required an0 dash from k=3", k, bus.an, bus.seg);
      end
    end
    while (!(m_idx == 2'd2 && m_cnt == 3'd5) && g < 40) begin tick(); g++; end
    if (g >= 40) begin
      n_cmp++; n_bad++;
      $display("FAIL dash_reset_align: idx2 cnt5 not reached in %0d cycles", g);
    end
    rst_n = 1'b0;
    bus.ones = 4'd3;
    tick();
    n_cmp++;
    if ({bus.an, bus.seg, bus.dp} !== {4'hF, 7'h7F, 1'b1} || e.an !== 4'hF) begin
      n_bad++;
      $display("FAIL mid_reset: an=%b seg=%b dp=%b, required an=1111 seg=1111111 dp=1", bus.an, bus.seg, bus.dp);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_cmp++;
      if ({bus.an, bus.seg, bus.dp} !== {e.an, e.seg, 1'b1}) begin
        n_bad++;
        $display("FAIL restart_sb k=%0d: an=%b seg=%b, required an=%b seg=%b", k, bus.an, bus.seg, e.an, e.seg);
      end
      n_cmp++;
      if ({bus.an, bus.seg} !== ((k >= 3) ? {4'b1110, 7'b0110000} : {4'hF, 7'h7F})) begin
        n_bad++;
        $display("FAIL restart k=%0d: an=%b seg=%b, required fresh ones=3 from k=3", k, bus.an, bus.seg);
      end
    end
  endtask

`ifdef SCORE_BLINK_EN
  task automatic test_blink();
    int lit;
    sync_frame();
    set_score(4'd1, 4'd2, 4'd3);
    for (int f = 0; f < 7; f++) begin
      lit = 0;
      for (int k = 1; k <= 32; k++) begin
        tick();
        n_cmp++;
        if ({bus.an, bus.seg, bus.dp} !== {e.an, e.seg, 1'b1}) begin
          n_bad++;
          $display("FAIL blink_sb f=%0d k=%0d: an=%b seg=%b, required an=%b seg=%b", f, k, bus.an, bus.seg, e.an, e.seg);
        end
        if (bus.an !== 4'hF) lit++;
        if (f == 0 && k == 16) bus.blink = 1'b1;
      end
      n_cmp++;
      if (lit !== ((f == 2 || f == 3 || f == 6) ? 0 : 18)) begin
        n_bad++;
        $display("FAIL blink_frame f=%0d: lit cycles %0d, required %0d", f, lit, (f == 2 || f == 3 || f == 6) ? 0 : 18);
      end
    end
    for (int k = 1; k <= 16; k++) begin
      tick();
      n_cmp++;
      if (bus.an !== 4'hF || e.an !== 4'hF) begin
        n_bad++;
        $display("FAIL blink_dark k=%0d: an=%b, required 1111", k, bus.an);
      end
    end
    bus.blink = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_cmp++;
      if ({bus.an, bus.seg} !== ((k >= 3) ? {4'b1011, 7'b1111001} : {4'hF, 7'h7F})) begin
        n_bad++;
        $display("FAIL blink_release k=%0d: an=%b seg=%b, required hundreds lit from k=3", k, bus.an, bus.seg);
      end
    end
  endtask
`endif

  initial begin
    set_score(4'd0, 4'd0, 4'd0);
`ifdef SCORE_BLINK_EN
    bus.blink = 1'b0;
`endif
    test_reset();
    test_first_frame();
    test_blanking();
    test_mid_frame();
    test_guard();
    test_dash_reset();
`ifdef SCORE_BLINK_EN
    test_blink();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/score_seg_scan.md
Name: score_seg_scan

Overview:
- Downstream consumer of the score BCD converter.
- Takes the three BCD digits `hundreds`, `tens` and `ones` and time-multiplexes them onto the board's 4-digit common-anode seven-segment display.
- Digit slots are scanned with a refresh counter. A short anode-off guard period at the start of each slot suppresses ghosting.
- The BCD inputs are captured once per frame so that a score change never tears mid-frame.
- Leading zeros are blanked, and the leftmost digit is always dark.

Parameters:
- REFRESH_TICKS, 100000, clk cycles per digit slot (1 kHz per slot at 100 MHz); legal range ≥ 4.
- BLANK_TICKS, 1000, guard cycles at slot start with all anodes off; legal range 1 .. REFRESH_TICKS-2.
- BLINK_FRAMES, 250, frames per blink half-period (used only with SCORE_BLINK_EN).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- hundreds  in  4  BCD hundreds digit from the score converter.
- tens  in  4  BCD tens digit.
- ones  in  4  BCD ones digit.
- blink  in  1  flash request, e.g. game over (present only with SCORE_BLINK_EN).
- an  out  4  anode enables, active low; an[0] is the rightmost digit.
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active low.
- dp  out  1  decimal point, active low; held at 1.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous, active-low (rst_n), sampled on the clk rising edge.
- Reset values: cnt=0, idx=0, shadow digits=0, an=4'b1111, seg=7'h7F, dp=1. With SCORE_BLINK_EN, frame_cnt=0 and blink_phase=0.
- Slot counter:
  - cnt counts 0..REFRESH_TICKS-1.
  - At REFRESH_TICKS-1, cnt returns to 0 and idx increments, wrapping 3→0.
  - A frame is 4*REFRESH_TICKS cycles.
- Input capture:
  - Shadow registers load {hundreds,tens,ones} on every cycle where cnt==0 && idx==0.
  - This includes the first cycle after reset release.
  - Input changes at any other time are ignored until the next frame start.
- Slot mapping: idx0=ones→an[0], idx1=tens→an[1], idx2=hundreds→an[2], idx3=unused→an[3].
- Blank conditions (a blank digit drives an=4'b1111, seg=7'h7F):
  - idx3 always.
  - Hundreds blank if shadow hundreds==0.
  - Tens blank if shadow hundreds==0 && shadow tens==0.
  - Ones never blanked, so score 0 shows "0".
- Guard period: while cnt < BLANK_TICKS, an=4'b1111 and seg=7'h7F.
- Active period: for the remaining cycles of the slot, exactly one anode is low, an = ~(4'b0001<<idx), and seg holds the decoded digit.
- Decode: standard 0-9 patterns; 0=7'b1000000, 1=7'b1111001, 5=7'b0010010, 7=7'b1111000, 8=7'b0000000. Any shadow digit >9 shows a dash, 7'b0111111, and is never blanked.
- Latency: an/seg/dp are registered, so they reflect cnt/idx/shadow state one cycle late. There is no combinational path from inputs to outputs.
- Mid-operation reset: low rst_n on any edge forces the reset values on the next cycle regardless of cnt or idx.

Optional Feature:
- Macro: SCORE_BLINK_EN.
- Defined:
  - The blink port exists.
  - frame_cnt increments at each frame start; at BLINK_FRAMES-1 it clears and toggles blink_phase.
  - While blink==1 && blink_phase==1, all slots are treated as guard: an=1111, seg=7F.
  - When blink falls, frame_cnt and blink_phase clear on the next cycle, so the display returns immediately.
- Undefined: no blink port, no frame_cnt, and the display is never suppressed beyond the guard/blank rules.

Decomposition:
- Package score_seg_pkg: SEG_BLANK=7'h7F, SEG_DASH=7'b0111111, the SEG_DIGIT[0:9] constant array, the digit-index typedef (2 bits), and AN_OFF=4'hF.
- Sub-module seg7_decode: combinational 4-bit BCD → 7-bit active-low pattern, with dash for >9. It is instantiated once on the muxed shadow digit.

Test Plan (REFRESH_TICKS=8, BLANK_TICKS=2, BLINK_FRAMES=2):
1. Reset hold → an=1111, seg=7F, dp=1; release with score 1/0/7 → the first active window (cnt=2..7, seen on cycles 3..8) shows an=1110 seg=1111000, then an=1101 seg=1000000, then an=1011 seg=1111001, then idx3 dark.
2. Score 0/0/5 → only an[0] is ever low, seg=0010010. Score 0/0/0 → an[0] shows 1000000, and an[1] and an[2] are never low.
3. Score 0/2/8 latched; hundreds changed to 1 at idx=1 mid-frame → the an[2] slot stays dark this frame; "1" appears at the next frame's idx2 slot.
4. Guard check → in every slot an=1111 for exactly 2 cycles following the slot boundary; never two anodes low at once across 3 full frames.
5. ones=4'hC → an[0] shows 0111111; rst_n pulsed low at idx=2 cnt=5 → next cycle an=1111, seg=7F, and scanning restarts at idx0 with a fresh capture.
6. With SCORE_BLINK_EN, blink=1 for 8 frames → alternating 2 frames lit / 2 frames dark; blink=0 during a dark phase → the next active window is lit.
